// File: rtl/spiadc_pkg.sv
// Shared types and constants for the MCP3201 read-side SPI master.
`timescale 1ns/1ps
`default_nettype none

package spiadc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [7:0] REG_CTRL      = 8'h40;
  localparam logic [7:0] REG_SAMPLE_LO = 8'h41;
  localparam logic [7:0] REG_SAMPLE_HI = 8'h42;

  localparam int CTRL_START = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_SRST  = 2;

  localparam int FRAME_EDGES = 15;
  localparam int NULL_EDGE   = 3;
  localparam int SAMPLE_BITS = 12;

  // Null bit plus result bits; earlier sample-period bits fall off the top.
  localparam int SHIFT_W = FRAME_EDGES - NULL_EDGE + 1;

  function automatic logic [7:0] sample_hi_byte(input logic       valid,
                                                input logic       nerr,
                                                input logic [3:0] hi);
    return {valid, 2'b00, nerr, hi};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spiadc_mcp3201_if.sv
// Register bus shared with the DAC driver: write strobe, address, data in/out.
`timescale 1ns/1ps
`default_nettype none

interface spiadc_mcp3201_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  we;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output we,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  we,
    input  addr,
    input  data_in,
    output data_out
  );

endinterface

`default_nettype wire

// File: rtl/mcp3201_rx_engine.sv
// SPI frame engine: SDO synchroniser, phase FSM, edge counter and shift register.
`timescale 1ns/1ps
`default_nettype none

module mcp3201_rx_engine
  import spiadc_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CONV_GAP = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trigger,
  input  logic                   cont,
  input  logic                   sdo,
  output logic                   sck,
  output logic                   ncs,
  output logic                   busy,
  output logic                   done,
  output logic [SAMPLE_BITS-1:0] sample,
  output logic                   sample_valid,
  output logic                   null_err
);

  localparam int CNT_MAX = (CLK_DIV > CONV_GAP) ? CLK_DIV : CONV_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int EDGE_W  = $clog2(FRAME_EDGES + 1);

  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(CONV_GAP - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(FRAME_EDGES);

  state_t              state;
  state_t              state_next;
  logic                frame_end;
  logic [CNT_W-1:0]    phase_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [SHIFT_W-1:0]  shreg;
  logic                sdo_meta;
  logic                sdo_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (phase_cnt == DIV_LAST) begin
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (phase_cnt == DIV_LAST) begin
          state_next = LOW;
        end
      end
      LOW: begin
        if (phase_cnt == DIV_LAST) begin
          if (edge_cnt == EDGE_LAST) begin
            frame_end  = 1'b1;
            state_next = GAP;
          end else begin
            state_next = HIGH;
          end
        end
      end
      GAP: begin
        if (phase_cnt == GAP_LAST) begin
          state_next = cont ? SETUP : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdo_meta     <= 1'b0;
      sdo_sync     <= 1'b0;
      phase_cnt    <= '0;
      edge_cnt     <= '0;
      shreg        <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      null_err     <= 1'b0;
      done         <= 1'b0;
      sck          <= 1'b0;
      ncs          <= 1'b1;
      busy         <= 1'b0;
    end else begin
      sdo_meta <= sdo;
      sdo_sync <= sdo_meta;

      if ((state_next != state) || (state == IDLE)) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + CNT_W'(1);
      end

      if (state_next == SETUP) begin
        edge_cnt <= '0;
      end else if ((state_next == HIGH) && (state != HIGH)) begin
        edge_cnt <= edge_cnt + EDGE_W'(1);
        shreg    <= {shreg[SHIFT_W-2:0], sdo_sync};
      end

      done <= frame_end;
      if (frame_end) begin
        sample       <= shreg[SAMPLE_BITS-1:0];
        null_err     <= shreg[SHIFT_W-1];
        sample_valid <= 1'b1;
      end

      sck  <= (state_next == HIGH);
      ncs  <= !(state_next inside {SETUP, HIGH, LOW});
      busy <= (state_next != IDLE);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spiadc_mcp3201.sv
// MCP3201 read-side SPI master: register file, trigger merge and read mux around the rx engine.
`timescale 1ns/1ps
`default_nettype none

module spiadc_mcp3201
  import spiadc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int CONV_GAP   = 8
) (
  input  logic                   clk,
  input  logic                   res,
  spiadc_mcp3201_if.slave        bus,
  input  logic                   start,
  input  logic                   SDO,
  output logic                   SCK,
  output logic                   nCS,
  output logic                   busy,
  output logic                   done,
  output logic [SAMPLE_BITS-1:0] sample,
  output logic                   sample_valid,
  output logic                   null_err
);

  logic                  ctrl_hit;
  logic                  soft_rst;
  logic                  int_rst;
  logic                  trigger;
  logic                  cont;
  logic [DATA_WIDTH-1:0] rd_data;

  assign ctrl_hit = bus.we && (bus.addr == DATA_WIDTH'(REG_CTRL));
  assign soft_rst = ctrl_hit && bus.data_in[CTRL_SRST];
  // SRST acts on the write edge itself, exactly like res.
  assign int_rst  = res || soft_rst;
  assign trigger  = start || (ctrl_hit && bus.data_in[CTRL_START]);

  always_ff @(posedge clk) begin
    if (int_rst) begin
      cont <= 1'b0;
    end else if (ctrl_hit) begin
      cont <= bus.data_in[CTRL_CONT];
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.addr)
      DATA_WIDTH'(REG_CTRL):      rd_data[CTRL_CONT] = cont;
      DATA_WIDTH'(REG_SAMPLE_LO): rd_data[7:0] = sample[7:0];
      DATA_WIDTH'(REG_SAMPLE_HI): rd_data[7:0] = sample_hi_byte(sample_valid, null_err,
                                                                sample[SAMPLE_BITS-1:8]);
      default:                    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (int_rst) begin
      bus.data_out <= '0;
    end else begin
      bus.data_out <= rd_data;
    end
  end

  mcp3201_rx_engine #(
    .CLK_DIV  (CLK_DIV),
    .CONV_GAP (CONV_GAP)
  ) u_rx_engine (
    .clk          (clk),
    .rst          (int_rst),
    .trigger      (trigger),
    .cont         (cont),
    .sdo          (SDO),
    .sck          (SCK),
    .ncs          (nCS),
    .busy         (busy),
    .done         (done),
    .sample       (sample),
    .sample_valid (sample_valid),
    .null_err     (null_err)
  );

endmodule

`default_nettype wire

// File: tb/tb_spiadc_mcp3201.sv
// Directed bench for spiadc_mcp3201 with a behavioural MCP3201 DOUT model.
`timescale 1ns/1ps
`default_nettype none

module tb_spiadc_mcp3201;
  import spiadc_pkg::*;

  localparam int DATA_WIDTH = 8;
  localparam int CLK_DIV    = 4;
  localparam int CONV_GAP   = 8;

  logic        clk   = 1'b0;
  logic        res   = 1'b1;
  logic        start = 1'b0;
  logic        SDO   = 1'b0;
  logic        SCK;
  logic        nCS;
  logic        busy;
  logic        done;
  logic [11:0] sample;
  logic        sample_valid;
  logic        null_err;

  int vectors     = 0;
  int miscompares = 0;

  spiadc_mcp3201_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  spiadc_mcp3201 #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLK_DIV    (CLK_DIV),
    .CONV_GAP   (CONV_GAP)
  ) dut (
    .clk          (clk),
    .res          (res),
    .bus          (bus.slave),
    .start        (start),
    .SDO          (SDO),
    .SCK          (SCK),
    .nCS          (nCS),
    .busy         (busy),
    .done         (done),
    .sample       (sample),
    .sample_valid (sample_valid),
    .null_err     (null_err)
  );

  always #5 clk = ~clk;

  // ADC model: frame bits {edge1, edge2, null, B11..B0}; next bit after each SCK fall.
  logic [14:0] frame_q[$];
  logic [14:0] cur_frame = '0;
  int          bit_idx   = 0;
  logic        ncs_d     = 1'b1;
  logic        sck_d     = 1'b0;
  always begin
    @(posedge clk);
    #2;
    if (nCS === 1'b0 && ncs_d !== 1'b0) begin
      if (frame_q.size() > 0) cur_frame = frame_q.pop_front();
      bit_idx = 0;
      SDO     = cur_frame[14];
    end else if (nCS === 1'b0 && SCK === 1'b0 && sck_d === 1'b1 && bit_idx < 14) begin
      bit_idx = bit_idx + 1;
      SDO     = cur_frame[14 - bit_idx];
    end
    ncs_d = nCS;
    sck_d = SCK;
  end

  int   cyc            = 0;
  int   sck_rises      = 0;
  int   ncs_low_cycles = 0;
  int   done_pulses    = 0;
  logic mon_sck_d      = 1'b0;
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (nCS === 1'b0) ncs_low_cycles = ncs_low_cycles + 1;
    if (SCK === 1'b1 && mon_sck_d !== 1'b1) sck_rises = sck_rises + 1;
    mon_sck_d = SCK;
    if (done === 1'b1) done_pulses = done_pulses + 1;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got no completion, want bench finished");
    $fatal(1);
  end

  task automatic pulse_reset();
    @(negedge clk) res = 1'b1;
    @(negedge clk);
    @(negedge clk) res = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.we = 1'b1; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    bus.we = 1'b0; bus.data_in = '0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk) bus.addr = a;
    @(negedge clk) d = bus.data_out;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_sck_edges(input int base, input int n);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sck_rises - base >= n) break;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    pulse_reset();
    vectors++;
    if ({nCS, SCK, busy, done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_pins: got nCS,SCK,busy,done=%b want 1000", {nCS, SCK, busy, done});
    end
    vectors++;
    if ({sample_valid, null_err, sample} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_sample: got %h want 0000", {sample_valid, null_err, sample});
    end
    rd(REG_CTRL, d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %h want 00", d);
    end
  endtask

  task automatic test_single();
    logic [7:0] d;
    bit ok;
    int n, b_ncs, b_sck, b_done;
    frame_q.push_back({2'b00, 1'b0, 12'hA5C});
    b_ncs = ncs_low_cycles; b_sck = sck_rises; b_done = done_pulses;
    pulse_start();
    vectors++;
    if ({nCS, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL trigger_latency: got nCS,busy=%b want 01", {nCS, busy});
    end
    wait_done(300, ok);
    vectors++;
    if (!ok || nCS !== 1'b1 || sample !== 12'hA5C) begin
      miscompares++;
      $display("FAIL single_done: got ok=%0d nCS=%b sample=%h want 1 1 a5c", ok, nCS, sample);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL busy_tail: got %0d cycles want 8", n);
    end
    vectors++;
    if (ncs_low_cycles - b_ncs != 124 || sck_rises - b_sck != 15 || done_pulses - b_done != 1) begin
      miscompares++;
      $display("FAIL single_frame: got ncs_low=%0d sck=%0d done=%0d want 124 15 1",
               ncs_low_cycles - b_ncs, sck_rises - b_sck, done_pulses - b_done);
    end
    vectors++;
    if ({sample_valid, null_err, sample} !== {2'b10, 12'hA5C}) begin
      miscompares++;
      $display("FAIL single_sample: got %h want 2a5c", {sample_valid, null_err, sample});
    end
    rd(REG_SAMPLE_LO, d);
    vectors++;
    if (d !== 8'h5C) begin
      miscompares++;
      $display("FAIL single_lo: got %h want 5c", d);
    end
    rd(REG_SAMPLE_HI, d);
    vectors++;
    if (d !== 8'h8A) begin
      miscompares++;
      $display("FAIL single_hi: got %h want 8a", d);
    end
  endtask

  task automatic test_null();
    logic [7:0] d;
    bit ok;
    frame_q.push_back({2'b00, 1'b1, 12'h123});
    pulse_start();
    wait_done(300, ok);
    wait_idle(20, ok);
    vectors++;
    if ({sample_valid, null_err, sample} !== {2'b11, 12'h123}) begin
      miscompares++;
      $display("FAIL null_sample: got %h want 3123", {sample_valid, null_err, sample});
    end
    rd(REG_SAMPLE_HI, d);
    vectors++;
    if (d !== 8'h91) begin
      miscompares++;
      $display("FAIL null_hi: got %h want 91", d);
    end
    rd(REG_SAMPLE_LO, d);
    vectors++;
    if (d !== 8'h23) begin
      miscompares++;
      $display("FAIL null_lo: got %h want 23", d);
    end
  endtask

  task automatic test_continuous();
    logic [7:0] d;
    bit ok;
    int t1, t2, t3, b_done;
    frame_q.push_back({2'b00, 1'b0, 12'h001});
    frame_q.push_back({2'b00, 1'b0, 12'hFFF});
    frame_q.push_back({2'b00, 1'b0, 12'h800});
    wr(REG_CTRL, 8'h02);
    rd(REG_CTRL, d);
    vectors++;
    if (d !== 8'h02 || nCS !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_ctrl: got ctrl=%h nCS=%b want 02 1", d, nCS);
    end
    wr(REG_CTRL, 8'h03);
    wait_done(300, ok);
    t1 = cyc;
    vectors++;
    if (!ok || sample !== 12'h001) begin
      miscompares++;
      $display("FAIL cont_frame1: got ok=%0d sample=%h want 1 001", ok, sample);
    end
    wait_done(300, ok);
    t2 = cyc;
    vectors++;
    if (!ok || sample !== 12'hFFF || t2 - t1 != 132) begin
      miscompares++;
      $display("FAIL cont_frame2: got ok=%0d sample=%h period=%0d want 1 fff 132", ok, sample, t2 - t1);
    end
    for (int i = 0; i < 50; i++) begin
      if (nCS === 1'b0) break;
      @(negedge clk);
    end
    wr(REG_CTRL, 8'h00);
    wait_done(300, ok);
    t3 = cyc;
    vectors++;
    if (!ok || sample !== 12'h800 || t3 - t2 != 132) begin
      miscompares++;
      $display("FAIL cont_frame3: got ok=%0d sample=%h period=%0d want 1 800 132", ok, sample, t3 - t2);
    end
    wait_idle(20, ok);
    b_done = done_pulses;
    repeat (200) @(negedge clk);
    vectors++;
    if (!ok || done_pulses != b_done || nCS !== 1'b1) begin
      miscompares++;
      $display("FAIL cont_stop: got idle=%0d extra_done=%0d nCS=%b want 1 0 1", ok, done_pulses - b_done, nCS);
    end
  endtask

  task automatic test_abort_res();
    int b_sck, b_done;
    frame_q.push_back({2'b00, 1'b0, 12'hABC});
    b_sck = sck_rises; b_done = done_pulses;
    pulse_start();
    wait_sck_edges(b_sck, 8);
    vectors++;
    if (sck_rises - b_sck != 8) begin
      miscompares++;
      $display("FAIL abort_reach: got %0d sck edges want 8", sck_rises - b_sck);
    end
    res = 1'b1;
    @(negedge clk) res = 1'b0;
    vectors++;
    if ({nCS, SCK, busy, done} !== 4'b1000 || bus.data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_pins: got nCS,SCK,busy,done=%b data_out=%h want 1000 00",
               {nCS, SCK, busy, done}, bus.data_out);
    end
    vectors++;
    if ({sample_valid, null_err, sample} !== 14'h0) begin
      miscompares++;
      $display("FAIL abort_sample: got %h want 0000", {sample_valid, null_err, sample});
    end
    repeat (200) @(negedge clk);
    vectors++;
    if (done_pulses != b_done || nCS !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_nodone: got done=%0d nCS=%b want 0 1", done_pulses - b_done, nCS);
    end
  endtask

  task automatic test_ignored_start();
    logic [7:0] d;
    bit ok;
    int b_ncs, b_sck, b_done;
    frame_q.push_back({2'b00, 1'b0, 12'h3C7});
    b_ncs = ncs_low_cycles; b_sck = sck_rises; b_done = done_pulses;
    @(negedge clk);
    start = 1'b1; bus.we = 1'b1; bus.addr = REG_CTRL; bus.data_in = 8'h01;
    @(negedge clk);
    start = 1'b0; bus.we = 1'b0; bus.data_in = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    @(negedge clk) start = 1'b0;
    repeat (46) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(300, ok);
    wait_idle(20, ok);
    repeat (20) @(negedge clk);
    vectors++;
    if (ncs_low_cycles - b_ncs != 124 || sck_rises - b_sck != 15 || done_pulses - b_done != 1) begin
      miscompares++;
      $display("FAIL ignore_frame: got ncs_low=%0d sck=%0d done=%0d want 124 15 1",
               ncs_low_cycles - b_ncs, sck_rises - b_sck, done_pulses - b_done);
    end
    vectors++;
    if (sample !== 12'h3C7) begin
      miscompares++;
      $display("FAIL ignore_sample: got %h want 3c7", sample);
    end
    rd(REG_CTRL, d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL start_selfclear: got %h want 00", d);
    end
  endtask

  task automatic test_unmapped_srst();
    logic [7:0] d;
    int b_sck, b_done;
    rd(8'h55, d);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL unmapped_read: got %h want 00", d);
    end
    wr(8'h55, 8'h03);
    vectors++;
    if ({nCS, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL unmapped_write: got nCS,busy=%b want 10", {nCS, busy});
    end
    frame_q.push_back({2'b00, 1'b1, 12'hFED});
    b_sck = sck_rises; b_done = done_pulses;
    wr(REG_CTRL, 8'h01);
    vectors++;
    if ({nCS, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL reg_start: got nCS,busy=%b want 01", {nCS, busy});
    end
    wait_sck_edges(b_sck, 8);
    wr(REG_CTRL, 8'h04);
    vectors++;
    if ({nCS, SCK, busy, done} !== 4'b1000 || bus.data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL srst_pins: got nCS,SCK,busy,done=%b data_out=%h want 1000 00",
               {nCS, SCK, busy, done}, bus.data_out);
    end
    vectors++;
    if ({sample_valid, null_err, sample} !== 14'h0) begin
      miscompares++;
      $display("FAIL srst_sample: got %h want 0000", {sample_valid, null_err, sample});
    end
    repeat (200) @(negedge clk);
    vectors++;
    if (done_pulses != b_done || nCS !== 1'b1) begin
      miscompares++;
      $display("FAIL srst_nodone: got done=%0d nCS=%b want 0 1", done_pulses - b_done, nCS);
    end
  endtask

  initial begin
    bus.we      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    test_reset();
    test_single();
    test_null();
    test_continuous();
    test_abort_res();
    test_ignored_start();
    test_unmapped_srst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spiadc_mcp3201.md
# spiadc_mcp3201

Read-side SPI master for the Microchip MCP3201 12-bit ADC. It drives nCS/SCK, shifts the conversion result in from the ADC's DOUT pin and presents it through the same 8-bit register port the DAC driver uses, so the control software can set the DAC and read the ADC back for loop-back and PMT scan verification. A conversion starts either from a hardware trigger or from a register write. A continuous mode re-triggers conversions back to back.

## Interface
Parameters:
- DATA_WIDTH, 8, width of the register data and address bus.
- CLK_DIV, 4, SCK half-period in clk cycles; minimum 3.
- CONV_GAP, 8, minimum number of clk cycles nCS stays high between conversions; minimum 1.

Ports:
- clk  in  1  system clock; the only clock.
- res  in  1  reset, synchronous, active-high.
- we  in  1  register write strobe.
- addr  in  DATA_WIDTH  register address.
- data_in  in  DATA_WIDTH  register write data.
- data_out  out  DATA_WIDTH  register read data, registered.
- start  in  1  hardware trigger pulse; ignored while busy.
- SDO  in  1  ADC DOUT pin, asynchronous.
- SCK  out  1  SPI clock; idles low.
- nCS  out  1  ADC chip select, active low.
- busy  out  1  high from the first nCS-low cycle through the end of the gap.
- done  out  1  one-cycle pulse when a new sample is stored.
- sample  out  12  last completed conversion result.
- sample_valid  out  1  sample holds a completed result.
- null_err  out  1  null bit of the last frame was read as 1.

## Operation
- Register map (unmapped addresses read 0x00, writes to them are ignored):
  - 0x40 CTRL (read/write).
    - bit0 START: self-clearing; reads back 0.
    - bit1 CONT: continuous mode.
    - bit2 SRST: self-clearing; same effect as res.
  - 0x41 SAMPLE_LO (read-only): sample[7:0].
  - 0x42 SAMPLE_HI (read-only): bit7 sample_valid, bit4 null_err, bits[3:0] sample[11:8].
- Trigger: start, or a CTRL write with bit0=1, taken only in IDLE. Both in the same cycle produce one conversion.
- SDO passes through a 2-flop synchroniser before use.
- FSM states: IDLE, SETUP, HIGH, LOW, GAP.
  - IDLE: nCS=1, SCK=0. On trigger go to SETUP.
  - SETUP: nCS=0, SCK=0 for CLK_DIV cycles, then go to HIGH.
  - HIGH: SCK=1 for CLK_DIV cycles. On the entry edge, shift the synchronised SDO into the shift register and increment the edge count.
  - LOW: SCK=0 for CLK_DIV cycles.
    - Return to HIGH until 15 HIGH phases have completed.
    - After the 15th LOW: nCS=1, go to GAP.
  - GAP: nCS=1 for CONV_GAP cycles. Then go to SETUP if CONT=1, otherwise to IDLE.
- Frame decode, by SCK rising edge: edges 1-2 are the ADC sample period (bits discarded), edge 3 is the null bit, edges 4-15 are B11..B0, MSB first.
- On leaving the 15th LOW:
  - sample ← B11..B0, sample_valid ← 1, null_err ← (null bit == 1).
  - done pulses for one cycle.
- sample and sample_valid hold until the next completed frame or a reset. An aborted frame never updates them.
- Reset (res or SRST), including mid-frame:
  - Next cycle: nCS=1, SCK=0, FSM=IDLE.
  - busy=0, done=0, sample=0, sample_valid=0, null_err=0, CTRL=0, data_out=0.
  - An aborted frame produces no done.
- Clearing CONT mid-frame lets the current frame finish, then the FSM returns to IDLE.

## Timing
- Trigger accepted at edge t: nCS=0 and busy=1 from t+1.
- nCS low for CLK_DIV·31 cycles (124 at CLK_DIV=4).
- SCK period: 2·CLK_DIV cycles (8 at CLK_DIV=4, i.e. 12.5 MHz SCK from a 100 MHz clk).
- Edge at which nCS returns high: done=1 and the new sample is visible on sample in that same cycle.
- busy falls CONV_GAP cycles after nCS rises.
- Continuous-mode frame-to-frame period: CLK_DIV·31 + CONV_GAP cycles.
- data_out: one-cycle latency from addr. It reflects a register write one cycle after the write edge.

## Structure
- Package spiadc_pkg holds:
  - state enum (IDLE, SETUP, HIGH, LOW, GAP);
  - register addresses 0x40/0x41/0x42;
  - CTRL bit indices;
  - FRAME_EDGES=15, NULL_EDGE=3.
- Sub-module mcp3201_rx_engine contains the synchroniser, FSM, counters and shift register.
- The top level holds the register file, trigger merge and read mux.

## Test plan
- CLK_DIV=4: ADC model returns 0xA5C with null bit 0; pulse start.
  - nCS low 124 cycles, exactly 15 SCK rising edges.
  - Then sample=0xA5C, done pulses once, SAMPLE_LO=0x5C, SAMPLE_HI=0x8A.
- ADC model drives null bit 1 with data 0x123 → sample=0x123, null_err=1, SAMPLE_HI=0x91.
- Write CTRL=0x02 then CTRL=0x03; model returns 0x001, 0xFFF, 0x800 → three consecutive done pulses 132 cycles apart, sample updated each time.
- Trigger, assert res at SCK edge 8 → nCS=1 and SCK=0 next cycle, no done, sample=0, sample_valid=0.
- Pulse start at cycles 2, 3 and 50 of a frame → ignored; exactly one frame and one done.
- Read address 0x55 → data_out=0x00. Write CTRL=0x04 mid-frame → same result as the res abort.
